demux_reg3: RTL and testbench

- Inverse of the datapath 3-way selector: steers one 32-bit source word to one of three registered destination slots, chosen by a 2-bit control code.
- Each slot is a one-entry buffer with a valid/ack handshake. Write-back producers (ALU result, memory data) can hand off a word without waiting for the consumer (PC, A/B registers, MDR) to be ready in the same cycle.
- Sits between the multicycle control unit's write-back stage and the destination registers.

---
 rtl/demux_reg3_pkg.sv | 11 +
 rtl/demux_slot.sv | 31 +++
 rtl/demux_reg3.sv | 78 +++++++
 tb/tb_demux_reg3.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/demux_reg3_pkg.sv
// Shared constants for the write-back demux: default data width, slot count
// and the destination-select encoding used by the matching selector mux.
package demux_reg3_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int NUM_SLOTS = 3;

  localparam logic [1:0] SEL_SAIDA0   = 2'b00;
  localparam logic [1:0] SEL_SAIDA1   = 2'b01;
  localparam logic [1:0] SEL_SAIDA2   = 2'b10;
  localparam logic [1:0] SEL_INVALIDO = 2'b11;
endpackage

// File: rtl/demux_slot.sv
// One-entry destination buffer: holds a word until the consumer acks it,
// and accepts a new word in the same cycle as the ack (no bubble).
module demux_slot
  import demux_reg3_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ack,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             free
);
  assign free = ~valid | ack;

  // Data is only ever overwritten by a write; an ack leaves the last word visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (wr_en) begin
      data  <= wr_data;
      valid <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux_reg3.sv
// Steers one source word into one of three registered slots selected by
// controle; code 11 is accepted, dropped and flagged with a one-cycle erro.
module demux_reg3
  import demux_reg3_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] entrada,
  input  logic [1:0]       controle,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] saida0,
  output logic [WIDTH-1:0] saida1,
  output logic [WIDTH-1:0] saida2,
  output logic             valid0,
  output logic             valid1,
  output logic             valid2,
  input  logic             ack0,
  input  logic             ack1,
  input  logic             ack2,
  output logic             erro
);
  logic [NUM_SLOTS-1:0]            wr_en, ack, vld, free;
  logic [NUM_SLOTS-1:0][WIDTH-1:0] dat;

  assign ack = {ack2, ack1, ack0};

  // Readiness depends only on the selected slot, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (controle)
      SEL_SAIDA0:   in_ready = free[0];
      SEL_SAIDA1:   in_ready = free[1];
      SEL_SAIDA2:   in_ready = free[2];
      SEL_INVALIDO: in_ready = 1'b1;
      default:      in_ready = 1'b0;
    endcase
  end

  always_comb begin
    wr_en = '0;
    if (in_valid && in_ready) begin
      case (controle)
        SEL_SAIDA0: wr_en[0] = 1'b1;
        SEL_SAIDA1: wr_en[1] = 1'b1;
        SEL_SAIDA2: wr_en[2] = 1'b1;
        default:    wr_en    = '0;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clock  (clock),
      .reset  (reset),
      .wr_en  (wr_en[k]),
      .wr_data(entrada),
      .ack    (ack[k]),
      .data   (dat[k]),
      .valid  (vld[k]),
      .free   (free[k])
    );
  end

  assign saida0 = dat[0];
  assign saida1 = dat[1];
  assign saida2 = dat[2];
  assign valid0 = vld[0];
  assign valid1 = vld[1];
  assign valid2 = vld[2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) erro <= 1'b0;
    else       erro <= in_valid && (controle == SEL_INVALIDO);
  end
endmodule

// File: tb/tb_demux_reg3.sv
// Scoreboarded bench for demux_reg3: directed test-plan sequences followed by
// random traffic, checked cycle by cycle against a slot-level reference model.
module tb_demux_reg3;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] entrada;
  logic [1:0]  controle;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] saida0, saida1, saida2;
  logic        valid0, valid1, valid2;
  logic        ack0, ack1, ack2;
  logic        erro;

  demux_reg3 #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .entrada(entrada), .controle(controle),
    .in_valid(in_valid), .in_ready(in_ready),
    .saida0(saida0), .saida1(saida1), .saida2(saida2),
    .valid0(valid0), .valid1(valid1), .valid2(valid2),
    .ack0(ack0), .ack1(ack1), .ack2(ack2), .erro(erro)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic             rdy;
    logic [2:0][31:0] d;
    logic [2:0]       v;
    logic             e;
  } rec_t;

  rec_t        expq[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model: what each destination currently holds.
  logic [31:0] m_data [3];
  bit          m_full [3];
  bit          m_erro;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_data[k] = '0;
      m_full[k] = 0;
    end
    m_erro = 0;
  endtask

  // Drive one cycle of inputs, record the expected view for this cycle,
  // then advance the model across the coming edge.
  task automatic cyc(input bit v, input logic [1:0] ctl, input logic [31:0] d, input logic [2:0] a);
    rec_t r;
    bit   rdy, acc;
    in_valid = v; controle = ctl; entrada = d;
    ack0 = a[0]; ack1 = a[1]; ack2 = a[2];
    rdy = (ctl == 2'd3) || !m_full[ctl] || a[ctl];
    r.rdy = rdy;
    r.e   = m_erro;
    for (int k = 0; k < 3; k++) begin
      r.d[k] = m_data[k];
      r.v[k] = m_full[k];
    end
    expq.push_back(r);
    acc = v && rdy;
    for (int k = 0; k < 3; k++) begin
      if (acc && ctl == 2'(k)) begin
        m_data[k] = d;
        m_full[k] = 1;
      end else if (a[k]) begin
        m_full[k] = 0;
      end
    end
    m_erro = acc && (ctl == 2'd3);
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; controle = 2'd0; entrada = '0;
    ack0 = 0; ack1 = 0; ack2 = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_saida0"}, saida0, 32'h0);
    chk({tag, "_saida1"}, saida1, 32'h0);
    chk({tag, "_saida2"}, saida2, 32'h0);
    chk({tag, "_valids"}, {29'h0, valid2, valid1, valid0}, 32'h0);
    chk({tag, "_erro"},   {31'h0, erro}, 32'h0);
  endtask

  // Monitor: mid-cycle, compare DUT outputs against the next expected record.
  always @(negedge clock) begin
    if (!reset && expq.size() > 0) begin
      rec_t r;
      r = expq.pop_front();
      chk("in_ready", {31'h0, in_ready}, {31'h0, r.rdy});
      chk("saida0",   saida0, r.d[0]);
      chk("saida1",   saida1, r.d[1]);
      chk("saida2",   saida2, r.d[2]);
      chk("valid",    {29'h0, valid2, valid1, valid0}, {29'h0, r.v});
      chk("erro",     {31'h0, erro}, {31'h0, r.e});
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    reset = 1;
    #1;
    check_reset_state("por");
    @(posedge clock);
    #1;
    reset = 0;
    @(posedge clock);
    #1;

    // Basic steer, then ack with data held
    cyc(1, 2'b01, 32'hDEADBEEF, 3'b000);
    cyc(0, 2'b00, 32'h0, 3'b000);
    cyc(0, 2'b00, 32'h0, 3'b010);
    cyc(0, 2'b00, 32'h0, 3'b000);

    // Backpressure on slot 0, released by ack0
    cyc(1, 2'b00, 32'h1, 3'b000);
    repeat (3) cyc(1, 2'b00, 32'h2, 3'b000);
    cyc(1, 2'b00, 32'h2, 3'b001);
    cyc(0, 2'b00, 32'h0, 3'b000);

    // Ack and write on slot 2 in the same cycle
    cyc(1, 2'b10, 32'hA, 3'b000);
    cyc(1, 2'b10, 32'hB, 3'b100);
    cyc(0, 2'b00, 32'h0, 3'b000);

    // Invalid code: accepted, dropped, one-cycle erro
    cyc(1, 2'b11, 32'h5, 3'b000);
    cyc(0, 2'b00, 32'h0, 3'b000);
    cyc(0, 2'b00, 32'h0, 3'b000);

    // Drain, then back-to-back routing; fourth write blocked
    cyc(0, 2'b00, 32'h0, 3'b111);
    cyc(1, 2'b00, 32'h1, 3'b000);
    cyc(1, 2'b10, 32'h2, 3'b000);
    cyc(1, 2'b01, 32'h3, 3'b000);
    cyc(1, 2'b00, 32'h4, 3'b000);
    cyc(0, 2'b00, 32'h0, 3'b000);

    // Reset between edges with all slots full
    idle_inputs();
    #2;
    reset = 1;
    #1;
    check_reset_state("midrst");
    model_reset();
    reset = 0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
          3'($urandom_range(0, 7) & $urandom_range(0, 7)));
    end
    idle_inputs();

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clock);
    n_checks++;
    if (expq.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d records left expected 0", expq.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
